// File: rtl/snn_pkg.sv
// Shared types and defaults for the SNN serial load path.
package snn_pkg;

  localparam int SNN_WORD_W = 8;
  localparam int SNN_CNT_W  = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_LATCH = 2'd2
  } snn_state_e;

  // Saturating increment for the per-frame word counter.
  function automatic logic [SNN_CNT_W-1:0] sat_inc(input logic [SNN_CNT_W-1:0] v);
    return (v == '1) ? v : v + {{(SNN_CNT_W-1){1'b0}}, 1'b1};
  endfunction

endpackage

// File: rtl/snn_tick_div.sv
// Modulo-DIV counter with synchronous clear; tick is high while the count sits at DIV-1.
module snn_tick_div #(
  parameter int DIV = 1
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic en,
  output logic tick
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] count;

  always_ff @(posedge clk) begin
    if (reset || clr) count <= '0;
    else if (en)      count <= tick ? '0 : count + CW'(1);
  end

  assign tick = (count == LAST);

endmodule

// File: rtl/snn_stream_tx.sv
// Parallel-to-serial loader: words in over valid/ready, MSB-first bits out with shift
// strobes, and a latch strobe after the frame's last word.
module snn_stream_tx
  import snn_pkg::*;
#(
  parameter int WORD_W  = SNN_WORD_W,
  parameter int CLK_DIV = 1
) (
  input  logic                 wb_clk_i,
  input  logic                 reset,
  input  logic [WORD_W-1:0]    s_data,
  input  logic                 s_last,
  input  logic                 s_valid,
  output logic                 s_ready,
  output logic                 ser_data,
  output logic                 ser_shift,
  output logic                 ser_latch,
  output logic                 busy,
  output logic [SNN_CNT_W-1:0] word_cnt
);

  localparam int BCW = $clog2(WORD_W + 1);
  localparam logic [BCW-1:0] LAST_BIT = BCW'(WORD_W - 1);

  snn_state_e             state;
  logic [WORD_W-1:0]      sreg;
  logic                   last_q;
  logic [BCW-1:0]         bit_cnt;
  logic [SNN_CNT_W-1:0]   cnt_q;
  logic                   accept, div_tick, tick_en, word_done;

  assign accept    = (state == ST_IDLE) && s_valid;
  assign tick_en   = (state == ST_SHIFT) && div_tick;
  assign word_done = tick_en && (bit_cnt == LAST_BIT);

  // Divider restarts on every accept so the first tick lands CLK_DIV cycles later.
  snn_tick_div #(.DIV(CLK_DIV)) u_div (
    .clk   (wb_clk_i),
    .reset (reset),
    .clr   (accept),
    .en    (state == ST_SHIFT),
    .tick  (div_tick)
  );

  always_ff @(posedge wb_clk_i) begin
    if (reset) begin
      state   <= ST_IDLE;
      sreg    <= '0;
      last_q  <= 1'b0;
      bit_cnt <= '0;
      cnt_q   <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (s_valid) begin
            sreg    <= s_data;
            last_q  <= s_last;
            bit_cnt <= '0;
            state   <= ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          if (tick_en) begin
            sreg    <= sreg << 1;
            bit_cnt <= bit_cnt + BCW'(1);
          end
          if (word_done) begin
            cnt_q <= sat_inc(cnt_q);
            state <= last_q ? ST_LATCH : ST_IDLE;
          end
        end
        ST_LATCH: begin
          cnt_q <= '0;
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // All outputs decode registered state only.
  assign s_ready   = (state == ST_IDLE);
  assign busy      = (state != ST_IDLE);
  assign ser_data  = sreg[WORD_W-1];
  assign ser_shift = tick_en;
  assign ser_latch = (state == ST_LATCH);
  assign word_cnt  = cnt_q;

endmodule

// File: tb/tb_snn_stream_tx.sv
// Directed bench for snn_stream_tx: default instance plus a CLK_DIV=3 instance.
module tb_snn_stream_tx;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] d_data, e_data;
  logic       d_last, d_valid, e_last, e_valid;
  logic       d_ready, d_sd, d_sh, d_la, d_busy;
  logic       e_ready, e_sd, e_sh, e_la, e_busy;
  logic [7:0] d_cnt, e_cnt;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  snn_stream_tx u_dut (
    .wb_clk_i(clk), .reset(reset), .s_data(d_data), .s_last(d_last), .s_valid(d_valid),
    .s_ready(d_ready), .ser_data(d_sd), .ser_shift(d_sh), .ser_latch(d_la),
    .busy(d_busy), .word_cnt(d_cnt)
  );

  snn_stream_tx #(.WORD_W(8), .CLK_DIV(3)) u_div3 (
    .wb_clk_i(clk), .reset(reset), .s_data(e_data), .s_last(e_last), .s_valid(e_valid),
    .s_ready(e_ready), .ser_data(e_sd), .ser_shift(e_sh), .ser_latch(e_la),
    .busy(e_busy), .word_cnt(e_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Handshake one word on the default instance and collect the 8 strobed bits.
  // Returns in cycle 9 relative to the accept edge.
  task automatic send_d(input logic [7:0] d, input logic last,
                        output logic [7:0] bits, output int nsh);
    int k = 0;
    while (!d_ready && k < 50) begin step(); k++; end
    chk("ready_wait", d_ready, 1);
    d_data = d; d_last = last; d_valid = 1'b1;
    step();
    d_valid = 1'b0;
    bits = '0; nsh = 0;
    for (int c = 1; c <= 8; c++) begin
      if (d_sh) begin bits = {bits[6:0], d_sd}; nsh++; end
      step();
    end
  endtask

  initial begin
    #200us;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [7:0] bits, pat;
    logic [7:0] words [3];
    int nsh, nla;

    reset = 1'b1;
    d_data = '0; d_last = 0; d_valid = 0;
    e_data = '0; e_last = 0; e_valid = 0;
    step(); step();
    chk("rst_ready", d_ready, 1);
    chk("rst_data",  d_sd,    0);
    chk("rst_shift", d_sh,    0);
    chk("rst_latch", d_la,    0);
    chk("rst_busy",  d_busy,  0);
    chk("rst_cnt",   d_cnt,   0);
    chk("rst_e_ready", e_ready, 1);
    chk("rst_e_busy",  e_busy,  0);
    reset = 1'b0;
    step();

    // Single last word; s_valid toggles with junk data during the shift.
    d_data = 8'hA5; d_last = 1; d_valid = 1;
    step();
    bits = '0;
    for (int c = 1; c <= 8; c++) begin
      chk("a5_shift", d_sh, 1);
      chk("a5_busy", d_busy, 1);
      bits = {bits[6:0], d_sd};
      d_valid = c[0]; d_data = 8'h00;
      step();
    end
    d_valid = 0;
    chk("a5_bits", bits, 8'hA5);
    chk("a5_latch_c9", d_la, 1);
    chk("a5_shift_c9", d_sh, 0);
    chk("a5_ready_c9", d_ready, 0);
    chk("a5_cnt_c9", d_cnt, 1);
    step();
    chk("a5_latch_c10", d_la, 0);
    chk("a5_ready_c10", d_ready, 1);
    chk("a5_cnt_c10", d_cnt, 0);

    // Back-to-back frame with s_valid held high.
    words[0] = 8'h0F; words[1] = 8'hF0; words[2] = 8'h3C;
    d_valid = 1;
    for (int w = 0; w < 3; w++) begin
      d_data = words[w]; d_last = (w == 2);
      chk("b2b_ready", d_ready, 1);
      step();
      if (w == 2) d_valid = 0;
      bits = '0; nsh = 0; nla = 0;
      for (int c = 1; c <= 8; c++) begin
        if (d_sh) begin bits = {bits[6:0], d_sd}; nsh++; end
        if (d_la) nla++;
        step();
      end
      chk("b2b_bits", bits, words[w]);
      chk("b2b_nshift", nsh, 8);
      chk("b2b_nlatch", nla, 0);
      if (w < 2) begin
        chk("b2b_cnt", d_cnt, w + 1);
        chk("b2b_nolatch", d_la, 0);
      end else begin
        chk("b2b_latch", d_la, 1);
        step();
        chk("b2b_latch_done", d_la, 0);
        chk("b2b_ready_end", d_ready, 1);
        chk("b2b_cnt_end", d_cnt, 0);
      end
    end

    // Divided clock on the CLK_DIV=3 instance.
    pat = 8'h81;
    e_data = pat; e_last = 0; e_valid = 1;
    step();
    e_valid = 0;
    for (int c = 1; c <= 24; c++) begin
      chk("div_shift", e_sh, (c % 3 == 0) ? 1 : 0);
      chk("div_data", e_sd, pat[7 - (c - 1) / 3]);
      chk("div_busy", e_busy, 1);
      step();
    end
    chk("div_busy_end", e_busy, 0);
    chk("div_ready_end", e_ready, 1);
    chk("div_cnt", e_cnt, 1);
    chk("div_latch", e_la, 0);

    // Reset during the 4th tick of a last word.
    d_data = 8'hFF; d_last = 1; d_valid = 1;
    step();
    d_valid = 0;
    step(); step(); step();
    chk("mid_shift_c4", d_sh, 1);
    reset = 1;
    step();
    reset = 0;
    chk("mid_busy", d_busy, 0);
    chk("mid_ready", d_ready, 1);
    chk("mid_cnt", d_cnt, 0);
    nsh = 0; nla = 0;
    for (int c = 0; c < 12; c++) begin
      if (d_sh) nsh++;
      if (d_la) nla++;
      step();
    end
    chk("mid_no_shift", nsh, 0);
    chk("mid_no_latch", nla, 0);
    send_d(8'h5A, 0, bits, nsh);
    chk("post_bits", bits, 8'h5A);
    chk("post_nshift", nsh, 8);
    chk("post_cnt", d_cnt, 1);

    // Saturation: count starts at 1, so 254 more words reach 255.
    for (int i = 0; i < 260; i++) begin
      send_d(i[7:0] ^ 8'h96, 0, bits, nsh);
      if (i == 100) chk("sat_cnt_102", d_cnt, 102);
      if (i == 252) chk("sat_cnt_254", d_cnt, 254);
      if (i == 253) chk("sat_cnt_255", d_cnt, 255);
    end
    chk("sat_bits", bits, 8'd259 ^ 8'h96);
    chk("sat_cnt_hold", d_cnt, 255);
    chk("sat_nolatch", d_la, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
